rv32_run_ctrl: RTL

//  Synthesisable run controller between the board/bench clk+rstn and one or more RV32 cores.
//  - Sequences reset release: hold, then staggered per-core release.
//  - Watches the data-memory write bus for a "tohost" exit write and reports pass/fail plus exit code.
//  - Enforces a cycle-count watchdog.
//  - Replaces open-loop bench reset with a reusable, end-of-test-aware block.

---
 rtl/rv32_pkg.sv | 22 ++
 rtl/rv32_rst_stagger.sv | 46 ++++
 rtl/rv32_run_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared types and constants for the RV32 run controller.
package rv32_pkg;

    typedef enum logic [2:0] {
        HOLD,
        RELEASE,
        RUN,
        DONE,
        TIMEOUT
    } run_state_e;

    localparam logic [31:0] TOHOST_ADDR_DEF = 32'h0000_01FC;
    localparam int unsigned EXIT_CODE_W     = 31;

    // Cycle count after reset at which channel ch leaves reset.
    function automatic int unsigned rel_point(input int unsigned hold,
                                              input int unsigned stagger,
                                              input int unsigned ch);
        return hold + ch * stagger;
    endfunction

endpackage

// File: rtl/rv32_rst_stagger.sv
// Staggered per-core reset release: counts cycles since reset/clear and
// releases channel i once the count reaches RST_HOLD + i*STAGGER.
module rv32_rst_stagger
    import rv32_pkg::*;
#(
    parameter int unsigned N_CH     = 2,
    parameter int unsigned RST_HOLD = 4,
    parameter int unsigned STAGGER  = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            clr,
    output logic [N_CH-1:0] core_rstn,
    output logic            all_rel
);

    localparam int unsigned T_LAST = rel_point(RST_HOLD, STAGGER, N_CH - 1);
    localparam int unsigned TW     = $clog2(T_LAST + 1) + 1;

    logic [TW-1:0]   t;
    logic [N_CH-1:0] rel_c;

    always_comb begin
        rel_c = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            rel_c[i] = (32'(t) >= rel_point(RST_HOLD, STAGGER, i));
        end
    end

    // Combinational so the FSM can enter RUN on the edge the last channel rises.
    assign all_rel = rel_c[N_CH-1];

    // t saturates at the last release point; compares stay true from there on.
    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            t         <= '0;
            core_rstn <= '0;
        end else begin
            if (t != TW'(T_LAST)) begin
                t <= t + TW'(1);
            end
            core_rstn <= rel_c;
        end
    end

endmodule

// File: rtl/rv32_run_ctrl.sv
// Run controller for RV32 cores: staggered reset release, tohost exit
// detection with pass/fail and exit code, and a RUN-cycle watchdog.
module rv32_run_ctrl #(
    parameter int unsigned N_CH        = 2,
    parameter int unsigned RST_HOLD    = 4,
    parameter int unsigned STAGGER     = 2,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TIMEOUT     = 100000,
    parameter logic [31:0] TOHOST_ADDR = rv32_pkg::TOHOST_ADDR_DEF
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             restart,
    input  logic                             mem_we,
    input  logic [31:0]                      mem_addr,
    input  logic [31:0]                      mem_wdata,
    output logic [N_CH-1:0]                  core_rstn,
    output logic                             running,
    output logic                             done,
    output logic                             pass,
    output logic                             timeout,
    output logic [rv32_pkg::EXIT_CODE_W-1:0] exit_code,
    output logic [CNT_W-1:0]                 cycle_cnt
);

    localparam bit               WD_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    rv32_pkg::run_state_e state;

    logic exit_hit_c;
    logic wd_hit_c;
    logic clr_c;
    logic all_rel;

    assign exit_hit_c = (state == rv32_pkg::RUN) && mem_we &&
                        (mem_addr == TOHOST_ADDR) && mem_wdata[0];
    assign wd_hit_c   = WD_EN && (state == rv32_pkg::RUN) && (cycle_cnt == WD_LAST);

    // Cores drop into reset on the edge that ends RUN and stay there until restart.
    assign clr_c = exit_hit_c || wd_hit_c ||
                   (state == rv32_pkg::DONE) || (state == rv32_pkg::TIMEOUT);

    rv32_rst_stagger #(
        .N_CH     (N_CH),
        .RST_HOLD (RST_HOLD),
        .STAGGER  (STAGGER)
    ) u_stagger (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (clr_c),
        .core_rstn (core_rstn),
        .all_rel   (all_rel)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= rv32_pkg::HOLD;
            running   <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            exit_code <= '0;
            cycle_cnt <= '0;
        end else begin
            case (state)
                rv32_pkg::HOLD, rv32_pkg::RELEASE: begin
                    if (all_rel) begin
                        state     <= rv32_pkg::RUN;
                        running   <= 1'b1;
                        cycle_cnt <= '0;
                    end else if (core_rstn[0]) begin
                        state <= rv32_pkg::RELEASE;
                    end
                end
                rv32_pkg::RUN: begin
                    cycle_cnt <= cycle_cnt + CNT_W'(1);
                    // Exit write takes precedence over a same-cycle watchdog expiry.
                    if (exit_hit_c) begin
                        state     <= rv32_pkg::DONE;
                        running   <= 1'b0;
                        done      <= 1'b1;
                        exit_code <= mem_wdata[31:1];
                        pass      <= (mem_wdata[31:1] == '0);
                    end else if (wd_hit_c) begin
                        state   <= rv32_pkg::TIMEOUT;
                        running <= 1'b0;
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                    end
                end
                rv32_pkg::DONE, rv32_pkg::TIMEOUT: begin
                    if (restart) begin
                        state     <= rv32_pkg::HOLD;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        timeout   <= 1'b0;
                        exit_code <= '0;
                        cycle_cnt <= '0;
                    end
                end
                default: begin
                    state <= rv32_pkg::HOLD;
                end
            endcase
        end
    end

endmodule
